// File: rtl/net_sync_pkg.sv
// net_sync_pkg: shared tags, field widths, TX state enum and W0/W1 helpers.
// Used by net_sync_ctrl and net_sync_rx.
package net_sync_pkg;

   localparam int X_W    = 11;
   localparam int Y_W    = 11;
   localparam int DIR_W  = 9;
   localparam int STAT_W = 2;
   localparam int SEQ_W  = 4;

   localparam logic [1:0] TAG_W0 = 2'b10;
   localparam logic [1:0] TAG_W1 = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SNAP,
      ST_SEND0,
      ST_SEND1
   } tx_state_t;

   typedef struct packed {
      logic [X_W-1:0]    x;
      logic [Y_W-1:0]    y;
      logic [DIR_W-1:0]  dir;
      logic [STAT_W-1:0] stat;
   } player_t;

   function automatic logic [31:0] pack_w0(
      input logic [SEQ_W-1:0] seq,
      input logic [X_W-1:0]   x,
      input logic [Y_W-1:0]   y
   );
      return {TAG_W0, seq, 4'b0, x, y};
   endfunction

   function automatic logic [31:0] pack_w1(
      input logic [SEQ_W-1:0]  seq,
      input logic [STAT_W-1:0] stat,
      input logic [DIR_W-1:0]  dir
   );
      return {TAG_W1, seq, 15'b0, stat, dir};
   endfunction

   function automatic logic [1:0] word_tag(input logic [31:0] w);
      return w[31:30];
   endfunction

   function automatic logic [SEQ_W-1:0] word_seq(input logic [31:0] w);
      return w[29:26];
   endfunction

   function automatic logic [X_W-1:0] w0_x(input logic [31:0] w);
      return w[21:11];
   endfunction

   function automatic logic [Y_W-1:0] w0_y(input logic [31:0] w);
      return w[10:0];
   endfunction

   function automatic logic [STAT_W-1:0] w1_stat(input logic [31:0] w);
      return w[10:9];
   endfunction

   function automatic logic [DIR_W-1:0] w1_dir(input logic [31:0] w);
      return w[8:0];
   endfunction

endpackage

// File: rtl/net_sync_rx.sv
// net_sync_rx: parses W0/W1 words, commits opponent state atomically and
// runs the link watchdog. Ports: clk/rst, frame_edge, rx word, opp_*, link_up.
module net_sync_rx
   import net_sync_pkg::*;
#(
   parameter int         LINK_TIMEOUT = 30,
   parameter logic [10:0] OPP_RST_X   = 11'd320,
   parameter logic [10:0] OPP_RST_Y   = 11'd320
) (
   input  logic              clk_in,
   input  logic              rst_in_n,
   input  logic              frame_edge,
   input  logic              rx_valid,
   input  logic [31:0]       rx_data,
   output logic [X_W-1:0]    opp_x_out,
   output logic [Y_W-1:0]    opp_y_out,
   output logic [DIR_W-1:0]  opp_dir_out,
   output logic [STAT_W-1:0] opp_stat_out,
   output logic              link_up_out
);

   localparam int CNT_W = $clog2(LINK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINK_TIMEOUT);

   logic             sh_valid;
   logic [SEQ_W-1:0] sh_seq;
   logic [X_W-1:0]   sh_x;
   logic [Y_W-1:0]   sh_y;
   logic [CNT_W-1:0] frame_cnt;
   logic             is_w0;
   logic             is_w1;
   logic             commit;

   always_comb begin
      is_w0  = rx_valid && (word_tag(rx_data) == TAG_W0);
      is_w1  = rx_valid && (word_tag(rx_data) == TAG_W1);
      commit = is_w1 && sh_valid && (word_seq(rx_data) == sh_seq);
   end

   // Any W1 consumes the shadow, matched or not.
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         sh_valid <= 1'b0;
         sh_seq   <= '0;
         sh_x     <= '0;
         sh_y     <= '0;
      end else if (is_w0) begin
         sh_valid <= 1'b1;
         sh_seq   <= word_seq(rx_data);
         sh_x     <= w0_x(rx_data);
         sh_y     <= w0_y(rx_data);
      end else if (is_w1) begin
         sh_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         opp_x_out    <= OPP_RST_X;
         opp_y_out    <= OPP_RST_Y;
         opp_dir_out  <= '0;
         opp_stat_out <= '0;
      end else if (commit) begin
         opp_x_out    <= sh_x;
         opp_y_out    <= sh_y;
         opp_dir_out  <= w1_dir(rx_data);
         opp_stat_out <= w1_stat(rx_data);
      end
   end

   // Starts saturated so the link reads down until the first commit.
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         frame_cnt <= CNT_MAX;
      end else if (commit) begin
         frame_cnt <= '0;
      end else if (frame_edge && (frame_cnt != CNT_MAX)) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   assign link_up_out = (frame_cnt < CNT_MAX);

endmodule

// File: rtl/net_sync_ctrl.sv
// net_sync_ctrl: per-frame player snapshot sent as a W0/W1 word pair, plus
// RX opponent state. Optional macro NET_SYNC_LOOPBACK_EN feeds TX into RX.
module net_sync_ctrl
   import net_sync_pkg::*;
#(
   parameter int          LINK_TIMEOUT = 30,
   parameter logic [10:0] OPP_RST_X    = 11'd320,
   parameter logic [10:0] OPP_RST_Y    = 11'd320
) (
   input  logic              clk_in,
   input  logic              rst_in_n,
   input  logic              vsync_in,
   input  logic [X_W-1:0]    player_x_in,
   input  logic [Y_W-1:0]    player_y_in,
   input  logic [DIR_W-1:0]  direction_in,
   input  logic [STAT_W-1:0] game_stat_in,
   output logic              tx_valid_out,
   output logic [31:0]       tx_data_out,
   input  logic              tx_ready_in,
   input  logic              rx_valid_in,
   input  logic [31:0]       rx_data_in,
   output logic [X_W-1:0]    opp_x_out,
   output logic [Y_W-1:0]    opp_y_out,
   output logic [DIR_W-1:0]  opp_dir_out,
   output logic [STAT_W-1:0] opp_stat_out,
   output logic              link_up_out,
   output logic [7:0]        overrun_cnt_out
);

   tx_state_t        state;
   tx_state_t        state_nx;
   logic             vsync_q;
   logic             frame_edge;
   logic             pend;
   logic             pend_nx;
   logic             ovr_inc;
   logic [SEQ_W-1:0] seq;
   player_t          snap;
   logic             rx_valid;
   logic [31:0]      rx_data;

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) vsync_q <= 1'b0;
      else           vsync_q <= vsync_in;
   end

   assign frame_edge = vsync_in & ~vsync_q;

   always_comb begin
      state_nx     = state;
      pend_nx      = pend;
      ovr_inc      = 1'b0;
      tx_valid_out = 1'b0;
      tx_data_out  = '0;
      // A busy FSM parks one edge; a second one is lost and counted.
      if (state != ST_IDLE && frame_edge) begin
         if (pend) ovr_inc = 1'b1;
         else      pend_nx = 1'b1;
      end
      unique case (state)
         ST_IDLE: begin
            if (frame_edge || pend) begin
               state_nx = ST_SNAP;
               pend_nx  = pend & frame_edge;
            end
         end
         ST_SNAP: state_nx = ST_SEND0;
         ST_SEND0: begin
            tx_valid_out = 1'b1;
            tx_data_out  = pack_w0(seq, snap.x, snap.y);
            if (tx_ready_in) state_nx = ST_SEND1;
         end
         ST_SEND1: begin
            tx_valid_out = 1'b1;
            tx_data_out  = pack_w1(seq, snap.stat, snap.dir);
            if (tx_ready_in) state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state           <= ST_IDLE;
         pend            <= 1'b0;
         seq             <= '0;
         overrun_cnt_out <= '0;
         snap            <= '0;
      end else begin
         state <= state_nx;
         pend  <= pend_nx;
         if (state == ST_SEND1 && tx_ready_in) seq <= seq + 1'b1;
         if (ovr_inc && overrun_cnt_out != 8'hFF)
            overrun_cnt_out <= overrun_cnt_out + 1'b1;
         if (state == ST_SNAP)
            snap <= '{player_x_in, player_y_in, direction_in, game_stat_in};
      end
   end

`ifdef NET_SYNC_LOOPBACK_EN
   assign rx_valid = tx_valid_out & tx_ready_in;
   assign rx_data  = tx_data_out;
`else
   assign rx_valid = rx_valid_in;
   assign rx_data  = rx_data_in;
`endif

   net_sync_rx #(
      .LINK_TIMEOUT (LINK_TIMEOUT),
      .OPP_RST_X    (OPP_RST_X),
      .OPP_RST_Y    (OPP_RST_Y)
   ) u_rx (
      .clk_in       (clk_in),
      .rst_in_n     (rst_in_n),
      .frame_edge   (frame_edge),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .opp_x_out    (opp_x_out),
      .opp_y_out    (opp_y_out),
      .opp_dir_out  (opp_dir_out),
      .opp_stat_out (opp_stat_out),
      .link_up_out  (link_up_out)
   );

endmodule
